// File: rtl/bht_update_ctrl_pkg.sv
// Shared core constants, FSM encoding and the update-queue entry type
// for the BHT update controller.
package bht_update_ctrl_pkg;

  localparam int IM_ADDR_BIT  = 32;
  localparam int BHT_ADDR_BIT = 3;
  localparam int BHT_SIZE     = 1 << BHT_ADDR_BIT;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  typedef struct packed {
    logic [IM_ADDR_BIT-1:0] pc;
    logic [IM_ADDR_BIT-1:0] target;
    logic                   taken;
  } bht_upd_t;

endpackage

// File: rtl/bht_update_ctrl_if.sv
// EX-resolution, fetch-correction and BHT write/invalidate signals
// shared between the pipeline (master) and the update controller (slave).
interface bht_update_ctrl_if;
  import bht_update_ctrl_pkg::*;

  logic                    res_valid;
  logic [IM_ADDR_BIT-1:0]  res_pc;
  logic [IM_ADDR_BIT-1:0]  res_target;
  logic [IM_ADDR_BIT-1:0]  res_pred_addr;
  logic                    res_taken;

  logic                    mispredict;
  logic [IM_ADDR_BIT-1:0]  redirect_addr;

  logic                    bht_w_en;
  logic [IM_ADDR_BIT-1:0]  bht_pc;
  logic [IM_ADDR_BIT-1:0]  bht_target;
  logic                    bht_succeed;
  logic                    bht_clr_en;
  logic [BHT_ADDR_BIT-1:0] bht_clr_idx;

  modport master (
    output res_valid, res_pc, res_target, res_pred_addr, res_taken,
    input  mispredict, redirect_addr,
    input  bht_w_en, bht_pc, bht_target, bht_succeed, bht_clr_en, bht_clr_idx
  );

  modport slave (
    input  res_valid, res_pc, res_target, res_pred_addr, res_taken,
    output mispredict, redirect_addr,
    output bht_w_en, bht_pc, bht_target, bht_succeed, bht_clr_en, bht_clr_idx
  );

endinterface

// File: rtl/bht_update_ctrl_fifo.sv
// bht_upd_fifo: small circular queue of pending BHT updates with a
// combinational head so a queued entry can be written the cycle after it lands.
module bht_upd_fifo
  import bht_update_ctrl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     clr,
  input  logic     push,
  input  logic     pop,
  input  bht_upd_t din,
  output logic     full,
  output logic     empty,
  output bht_upd_t head
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  bht_upd_t        mem [DEPTH];
  logic [PW-1:0]   wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0]   rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0]   count_reg, count_next;

  assign full  = (count_reg == CW'(DEPTH));
  assign empty = (count_reg == '0);
  assign head  = mem[rd_ptr_reg];

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (clr) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (push) wr_ptr_next = wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_next = rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_next = count_reg + 1'b1;
        2'b01:   count_next = count_reg - 1'b1;
        default: count_next = count_reg;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clr) mem[wr_ptr_reg] <= din;
  end

endmodule

// File: rtl/bht_update_ctrl.sv
// BHT update controller: computes fetch correction, queues resolved branches
// for BHT writes, sequences a full-table invalidate and counts mispredicts.
module bht_update_ctrl
  import bht_update_ctrl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                clr_req,
  bht_update_ctrl_if.slave    bus,
  output logic                busy,
  output logic                stall_req,
  output logic [15:0]         mis_cnt
);

  state_t                  state_reg, state_next;
  logic [BHT_ADDR_BIT-1:0] idx_reg, idx_next;
  logic [15:0]             mis_cnt_reg;
  logic [IM_ADDR_BIT-1:0]  correct;
  logic                    fifo_push, fifo_pop, fifo_clr;
  logic                    fifo_full, fifo_empty;
  logic                    clr_en;
  bht_upd_t                fifo_din, fifo_head;

  assign correct           = bus.res_taken ? bus.res_target : bus.res_pc + IM_ADDR_BIT'(4);
  assign bus.mispredict    = bus.res_valid && (correct != bus.res_pred_addr);
  assign bus.redirect_addr = correct;

  assign fifo_din = '{pc: bus.res_pc, target: bus.res_target, taken: bus.res_taken};
  assign fifo_pop = en && (state_reg == ST_IDLE) && !fifo_empty;

  // Head fields are gated so an empty (or just-reset) queue presents zeros.
  assign bus.bht_w_en    = fifo_pop;
  assign bus.bht_pc      = fifo_empty ? '0 : fifo_head.pc;
  assign bus.bht_target  = fifo_empty ? '0 : fifo_head.target;
  assign bus.bht_succeed = fifo_empty ? 1'b0 : fifo_head.taken;
  assign bus.bht_clr_en  = clr_en;
  assign bus.bht_clr_idx = idx_reg;

  assign stall_req = bus.res_valid && fifo_full && !fifo_pop;
  assign mis_cnt   = mis_cnt_reg;

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    fifo_push  = 1'b0;
    fifo_clr   = 1'b0;
    busy       = 1'b0;
    clr_en     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (en) begin
          if (clr_req) begin
            fifo_clr   = 1'b1;
            state_next = ST_CLEAR;
            idx_next   = '0;
          end else if (bus.res_valid && (!fifo_full || fifo_pop)) begin
            fifo_push = 1'b1;
          end
        end
      end
      ST_CLEAR: begin
        busy   = 1'b1;
        clr_en = 1'b1;
        if (en) begin
          if (idx_reg == BHT_ADDR_BIT'(BHT_SIZE - 1)) begin
            state_next = ST_IDLE;
            idx_next   = '0;
          end else begin
            idx_next = idx_reg + 1'b1;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      idx_reg     <= '0;
      mis_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      if (en && (state_reg == ST_IDLE) && bus.mispredict && (mis_cnt_reg != 16'hFFFF))
        mis_cnt_reg <= mis_cnt_reg + 16'd1;
    end
  end

  bht_upd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (fifo_clr),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (fifo_din),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

endmodule

// File: tb/tb_bht_update_ctrl.sv
// Directed bench for bht_update_ctrl: mispredict/redirect, queued writes,
// enable freeze, table clear, reset mid-clear and mis_cnt saturation.
module tb_bht_update_ctrl;
  import bht_update_ctrl_pkg::*;

  logic        clk;
  logic        rst;
  logic        en;
  logic        clr_req;
  logic        busy;
  logic        stall_req;
  logic [15:0] mis_cnt;

  int total = 0;
  int bad   = 0;

  bht_update_ctrl_if bus ();

  bht_update_ctrl #(
    .DEPTH (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .clr_req   (clr_req),
    .bus       (bus.slave),
    .busy      (busy),
    .stall_req (stall_req),
    .mis_cnt   (mis_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_res(input logic v, input logic [31:0] pc, input logic [31:0] tgt,
                         input logic tk, input logic [31:0] pred);
    bus.res_valid     = v;
    bus.res_pc        = pc;
    bus.res_target    = tgt;
    bus.res_taken     = tk;
    bus.res_pred_addr = pred;
  endtask

  initial begin
    rst = 1'b0;
    en = 1'b0;
    clr_req = 1'b0;
    set_res(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    #1 rst = 1'b1;
    #1;
    $display("txn reset asserted");
    check("rst_w_en",    32'(bus.bht_w_en),    32'd0);
    check("rst_clr_en",  32'(bus.bht_clr_en),  32'd0);
    check("rst_busy",    32'(busy),            32'd0);
    check("rst_stall",   32'(stall_req),       32'd0);
    check("rst_bht_pc",  32'(bus.bht_pc),      32'd0);
    check("rst_bht_tgt", 32'(bus.bht_target),  32'd0);
    check("rst_succeed", 32'(bus.bht_succeed), 32'd0);
    check("rst_clr_idx", 32'(bus.bht_clr_idx), 32'd0);
    check("rst_mis_cnt", 32'(mis_cnt),         32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Taken branch mispredicted as fall-through.
    en = 1'b1;
    set_res(1'b1, 32'h40, 32'h80, 1'b1, 32'h44);
    #1;
    $display("txn taken mispredict pc=0x40");
    check("t1_mispredict", 32'(bus.mispredict), 32'd1);
    check("t1_redirect",   bus.redirect_addr,   32'h80);
    check("t1_no_bypass",  32'(bus.bht_w_en),   32'd0);
    step();
    set_res(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    #1;
    check("t1_mis_cnt", 32'(mis_cnt),         32'd1);
    check("t1_w_en",    32'(bus.bht_w_en),    32'd1);
    check("t1_bht_pc",  bus.bht_pc,           32'h40);
    check("t1_bht_tgt", bus.bht_target,       32'h80);
    check("t1_succeed", 32'(bus.bht_succeed), 32'd1);
    step();
    check("t1_drained", 32'(bus.bht_w_en), 32'd0);

    // Not-taken branch correctly predicted.
    set_res(1'b1, 32'h10, 32'h99, 1'b0, 32'h14);
    #1;
    $display("txn not-taken correct pc=0x10");
    check("t2_mispredict", 32'(bus.mispredict), 32'd0);
    check("t2_redirect",   bus.redirect_addr,   32'h14);
    step();
    set_res(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    #1;
    check("t2_w_en",    32'(bus.bht_w_en),    32'd1);
    check("t2_bht_pc",  bus.bht_pc,           32'h10);
    check("t2_succeed", 32'(bus.bht_succeed), 32'd0);
    check("t2_mis_cnt", 32'(mis_cnt),         32'd1);
    step();
    check("t2_drained", 32'(bus.bht_w_en), 32'd0);

    // Enable low: four updates presented, nothing may be captured.
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_res(1'b1, 32'h100 + 32'(i * 4), 32'h180, 1'b1, 32'h0);
      #1;
      $display("txn frozen update %0d", i);
      check("t3_frozen_w_en", 32'(bus.bht_w_en), 32'd0);
      step();
    end
    set_res(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    check("t3_frozen_mis_cnt", 32'(mis_cnt), 32'd1);
    en = 1'b1;
    #1;
    check("t3_none_queued", 32'(bus.bht_w_en), 32'd0);
    step();

    // Five back-to-back updates; each write trails its push by one cycle.
    for (int i = 0; i < 5; i++) begin
      set_res(1'b1, 32'h200 + 32'(i * 16), 32'h300 + 32'(i * 16), 1'b1, 32'h300 + 32'(i * 16));
      #1;
      $display("txn burst update %0d pc=0x%0h", i, 32'h200 + 32'(i * 16));
      check("t3_stall", 32'(stall_req), 32'd0);
      if (i == 0) begin
        check("t3_w_en_first", 32'(bus.bht_w_en), 32'd0);
      end else begin
        check("t3_w_en",   32'(bus.bht_w_en), 32'd1);
        check("t3_bht_pc", bus.bht_pc,        32'h200 + 32'((i - 1) * 16));
        check("t3_bht_tgt", bus.bht_target,   32'h300 + 32'((i - 1) * 16));
      end
      step();
    end
    set_res(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    #1;
    check("t3_last_w_en",  32'(bus.bht_w_en), 32'd1);
    check("t3_last_pc",    bus.bht_pc,        32'h240);
    check("t3_mis_cnt",    32'(mis_cnt),      32'd1);
    step();
    check("t3_drained", 32'(bus.bht_w_en), 32'd0);

    // Clear request coincident with a third update: that update is dropped.
    set_res(1'b1, 32'h500, 32'h0, 1'b0, 32'h504);
    step();
    set_res(1'b1, 32'h510, 32'h0, 1'b0, 32'h514);
    #1;
    check("t4_w_en_a", 32'(bus.bht_w_en), 32'd1);
    check("t4_pc_a",   bus.bht_pc,        32'h500);
    step();
    set_res(1'b1, 32'h520, 32'h600, 1'b1, 32'h524);
    clr_req = 1'b1;
    #1;
    $display("txn clear request");
    check("t4_w_en_b", 32'(bus.bht_w_en), 32'd1);
    check("t4_pc_b",   bus.bht_pc,        32'h510);
    check("t4_busy0",  32'(busy),         32'd0);
    step();
    for (int i = 0; i < 8; i++) begin
      clr_req = (i == 2);
      if (i == 7) set_res(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
      #1;
      $display("txn clear idx %0d", i);
      check("t4_busy",    32'(busy),            32'd1);
      check("t4_clr_en",  32'(bus.bht_clr_en),  32'd1);
      check("t4_clr_idx", 32'(bus.bht_clr_idx), 32'(i));
      check("t4_no_w_en", 32'(bus.bht_w_en),    32'd0);
      step();
    end
    clr_req = 1'b0;
    #1;
    check("t4_idle_busy",   32'(busy),           32'd0);
    check("t4_idle_clr_en", 32'(bus.bht_clr_en), 32'd0);
    check("t4_discarded",   32'(bus.bht_w_en),   32'd0);
    check("t4_mis_cnt",     32'(mis_cnt),        32'd2);
    step();
    check("t4_still_empty", 32'(bus.bht_w_en), 32'd0);

    // Reset pulsed in the middle of a clear sequence.
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    step();
    step();
    step();
    check("t5_idx3", 32'(bus.bht_clr_idx), 32'd3);
    #2 rst = 1'b1;
    #1;
    $display("txn reset mid-clear");
    check("t5_clr_en_drop", 32'(bus.bht_clr_en),  32'd0);
    check("t5_busy_drop",   32'(busy),            32'd0);
    check("t5_idx_reset",   32'(bus.bht_clr_idx), 32'd0);
    check("t5_mis_cnt",     32'(mis_cnt),         32'd0);
    @(negedge clk);
    rst = 1'b0;
    step();
    check("t5_after_busy",   32'(busy),            32'd0);
    check("t5_after_idx",    32'(bus.bht_clr_idx), 32'd0);
    check("t5_after_clr_en", 32'(bus.bht_clr_en),  32'd0);
    check("t5_after_w_en",   32'(bus.bht_w_en),    32'd0);

    // Drive mis_cnt up to 0xFFFE with continuous mispredicts, then saturate.
    set_res(1'b1, 32'h700, 32'h800, 1'b1, 32'h704);
    repeat (65534) step();
    $display("txn mis_cnt preload");
    check("t6_preload", 32'(mis_cnt), 32'h0000FFFE);
    check("t6_stall",   32'(stall_req), 32'd0);
    repeat (3) step();
    $display("txn mis_cnt saturate");
    check("t6_saturate", 32'(mis_cnt), 32'h0000FFFF);
    set_res(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    step();
    check("t6_hold", 32'(mis_cnt), 32'h0000FFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
